// File: rtl/merger_pkg.sv
// Shared constants and types for the beat-to-word merger.
package merger_pkg;

  localparam int MRG_DATA_W   = 32;
  localparam int MRG_BEAT_NUM = 4;

  // Source selected for the output register on a given cycle.
  typedef enum logic [1:0] {
    LOAD_NONE,
    LOAD_BEAT,
    LOAD_PEND
  } load_sel_e;

endpackage

// File: rtl/merger.sv
// Packs DATA_W beats into a BEAT_NUM-beat word with keep mask; a finished word that
// cannot leave yet is parked in the accumulator and input is stalled until it drains.
module merger
  import merger_pkg::*;
#(
  parameter int DATA_W   = MRG_DATA_W,
  parameter int BEAT_NUM = MRG_BEAT_NUM
) (
  input  logic                       clk,
  input  logic                       rst_n,
  input  logic [DATA_W-1:0]          bwd_data,
  input  logic                       bwd_vld,
  output logic                       bwd_rdy,
  input  logic                       bwd_last,
  output logic [DATA_W*BEAT_NUM-1:0] fwd_data,
  output logic [BEAT_NUM-1:0]        fwd_keep,
  output logic                       fwd_vld,
  input  logic                       fwd_rdy
);

  localparam int                 CNT_W   = $clog2(BEAT_NUM);
  localparam int                 WORD_W  = DATA_W * BEAT_NUM;
  localparam logic [CNT_W-1:0]   CNT_MAX = CNT_W'(BEAT_NUM - 1);

  logic [DATA_W-1:0]   acc_q [BEAT_NUM];
  logic [CNT_W-1:0]    cnt_q, cnt_d;
  logic                pend_q, pend_d;
  logic [BEAT_NUM-1:0] pkeep_q, pkeep_d;
  logic [WORD_W-1:0]   data_q;
  logic [BEAT_NUM-1:0] keep_q, keep_d;
  logic                vld_q, vld_d;

  logic                bwd_hsk, fwd_hsk, closing, out_free;
  logic [BEAT_NUM-1:0] keep_new;
  logic [WORD_W-1:0]   beat_word, pend_word;
  load_sel_e           load_sel;

  function automatic logic [BEAT_NUM-1:0] keep_mask(input logic [CNT_W-1:0] c);
    logic [BEAT_NUM-1:0] m;
    m = '0;
    for (int i = 0; i < BEAT_NUM; i++) begin
      m[i] = (i <= int'(c));
    end
    return m;
  endfunction

  assign bwd_rdy  = ~pend_q;
  assign bwd_hsk  = bwd_vld & bwd_rdy;
  assign fwd_hsk  = vld_q & fwd_rdy;
  assign out_free = ~vld_q | fwd_rdy;
  assign closing  = bwd_hsk & (bwd_last | (cnt_q == CNT_MAX));
  assign keep_new = keep_mask(cnt_q);

  // Word images: lanes outside the keep mask are forced to zero so stale acc never leaks.
  always_comb begin
    beat_word = '0;
    pend_word = '0;
    for (int i = 0; i < BEAT_NUM; i++) begin
      if (keep_new[i]) begin
        beat_word[i*DATA_W +: DATA_W] = (i == int'(cnt_q)) ? bwd_data : acc_q[i];
      end
      if (pkeep_q[i]) begin
        pend_word[i*DATA_W +: DATA_W] = acc_q[i];
      end
    end
  end

  always_comb begin
    load_sel = LOAD_NONE;
    cnt_d    = cnt_q;
    pend_d   = pend_q;
    pkeep_d  = pkeep_q;
    keep_d   = keep_q;
    vld_d    = vld_q;
    if (bwd_hsk) begin
      cnt_d = closing ? '0 : cnt_q + 1'b1;
    end
    if (pend_q) begin
      if (out_free) begin
        load_sel = LOAD_PEND;
        pend_d   = 1'b0;
        keep_d   = pkeep_q;
        vld_d    = 1'b1;
      end
    end else if (closing) begin
      if (out_free) begin
        load_sel = LOAD_BEAT;
        keep_d   = keep_new;
        vld_d    = 1'b1;
      end else begin
        pend_d  = 1'b1;
        pkeep_d = keep_new;
      end
    end else if (fwd_hsk) begin
      vld_d = 1'b0;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt_q   <= '0;
      pend_q  <= 1'b0;
      pkeep_q <= '0;
      keep_q  <= '0;
      vld_q   <= 1'b0;
    end else begin
      cnt_q   <= cnt_d;
      pend_q  <= pend_d;
      pkeep_q <= pkeep_d;
      keep_q  <= keep_d;
      vld_q   <= vld_d;
    end
  end

  // Datapath storage carries no reset; contents only matter once fwd_vld is raised.
  always_ff @(posedge clk) begin
    if (bwd_hsk) begin
      acc_q[cnt_q] <= bwd_data;
    end
    case (load_sel)
      LOAD_BEAT: data_q <= beat_word;
      LOAD_PEND: data_q <= pend_word;
      default:   data_q <= data_q;
    endcase
  end

  assign fwd_data = data_q;
  assign fwd_keep = keep_q;
  assign fwd_vld  = vld_q;

endmodule

// File: tb/tb_merger.sv
// Scoreboard bench for merger with DATA_W=8, BEAT_NUM=4.
module tb_merger;

  localparam int DW = 8;
  localparam int BN = 4;

  logic          clk = 1'b0;
  logic          rst_n;
  logic [DW-1:0] bwd_data;
  logic          bwd_vld;
  logic          bwd_rdy;
  logic          bwd_last;
  logic [DW*BN-1:0] fwd_data;
  logic [BN-1:0] fwd_keep;
  logic          fwd_vld;
  logic          fwd_rdy;

  merger #(.DATA_W(DW), .BEAT_NUM(BN)) dut (
    .clk      (clk),
    .rst_n    (rst_n),
    .bwd_data (bwd_data),
    .bwd_vld  (bwd_vld),
    .bwd_rdy  (bwd_rdy),
    .bwd_last (bwd_last),
    .fwd_data (fwd_data),
    .fwd_keep (fwd_keep),
    .fwd_vld  (fwd_vld),
    .fwd_rdy  (fwd_rdy)
  );

  always #5 clk = ~clk;

  int n_checks = 0;
  int n_errors = 0;
  int cyc = 0;

  logic [BN+DW*BN-1:0] exp_q[$];
  logic [DW*BN-1:0]    m_word;
  logic [BN-1:0]       m_keep;
  int                  m_cnt;

  bit  rec_on = 1'b0;
  int  hsk_cyc[$];
  int  stall_cnt = 0;

  task automatic check_val(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  task automatic model_clear();
    m_word = '0;
    m_keep = '0;
    m_cnt  = 0;
  endtask

  task automatic model_beat(input logic [DW-1:0] d, input logic last);
    m_word[m_cnt*DW +: DW] = d;
    m_keep[m_cnt] = 1'b1;
    m_cnt++;
    if (last || m_cnt == BN) begin
      exp_q.push_back({m_keep, m_word});
      model_clear();
    end
  endtask

  // Drives one beat and returns one #1 after the posedge on which it was accepted.
  task automatic send_beat(input logic [DW-1:0] d, input logic last);
    bit acc;
    bwd_vld  = 1'b1;
    bwd_data = d;
    bwd_last = last;
    for (int t = 0; t < 200; t++) begin
      @(negedge clk);
      acc = bwd_rdy;
      @(posedge clk);
      #1;
      if (acc) begin
        model_beat(d, last);
        return;
      end
    end
    check_val("bwd_accept_timeout", 64'd0, 64'd1);
  endtask

  task automatic idle(input int n);
    bwd_vld  = 1'b0;
    bwd_last = 1'b0;
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  always @(posedge clk) cyc++;

  // Output monitor: pops the scoreboard on every output handshake and checks hold stability.
  logic          held_prev = 1'b0;
  logic [DW*BN-1:0] data_prev;
  logic [BN-1:0] keep_prev;
  always @(negedge clk) begin
    if (!rst_n) begin
      held_prev = 1'b0;
    end else begin
      if (held_prev) begin
        check_val("hold_vld", {63'd0, fwd_vld}, 64'd1);
        check_val("hold_data", {32'd0, fwd_data}, {32'd0, data_prev});
        check_val("hold_keep", {60'd0, fwd_keep}, {60'd0, keep_prev});
      end
      if (rec_on && bwd_vld && !bwd_rdy) stall_cnt++;
      if (fwd_vld && fwd_rdy) begin
        if (exp_q.size() == 0) begin
          check_val("unexpected_word", {28'd0, fwd_keep, fwd_data}, 64'd0);
        end else begin
          logic [BN+DW*BN-1:0] e;
          e = exp_q.pop_front();
          check_val("word_data", {32'd0, fwd_data}, {32'd0, e[DW*BN-1:0]});
          check_val("word_keep", {60'd0, fwd_keep}, {60'd0, e[BN+DW*BN-1:DW*BN]});
        end
        if (rec_on) hsk_cyc.push_back(cyc);
      end
      held_prev = fwd_vld && !fwd_rdy;
      data_prev = fwd_data;
      keep_prev = fwd_keep;
    end
  end

  initial begin
    rst_n    = 1'b0;
    bwd_data = '0;
    bwd_vld  = 1'b0;
    bwd_last = 1'b0;
    fwd_rdy  = 1'b1;
    model_clear();
    repeat (3) @(posedge clk);
    #1;
    check_val("rst_vld", {63'd0, fwd_vld}, 64'd0);
    check_val("rst_keep", {60'd0, fwd_keep}, 64'd0);
    check_val("rst_rdy", {63'd0, bwd_rdy}, 64'd1);
    rst_n = 1'b1;
    idle(2);

    // Full 4-beat word, emitted for one cycle
    send_beat(8'h11, 1'b0);
    send_beat(8'h22, 1'b0);
    send_beat(8'h33, 1'b0);
    send_beat(8'h44, 1'b0);
    bwd_vld = 1'b0;
    check_val("t1_vld", {63'd0, fwd_vld}, 64'd1);
    check_val("t1_data", {32'd0, fwd_data}, 64'h44332211);
    check_val("t1_keep", {60'd0, fwd_keep}, 64'hF);
    idle(1);
    check_val("t1_vld_drop", {63'd0, fwd_vld}, 64'd0);

    // Short word, then the next beat starts at lane 0
    send_beat(8'hAA, 1'b0);
    send_beat(8'hBB, 1'b1);
    bwd_vld = 1'b0;
    check_val("t2_data", {32'd0, fwd_data}, 64'h0000BBAA);
    check_val("t2_keep", {60'd0, fwd_keep}, 64'h3);
    idle(1);
    send_beat(8'hCC, 1'b0);
    send_beat(8'hDD, 1'b1);
    idle(2);

    // Back-to-back words at full rate
    rec_on = 1'b1;
    for (int w = 0; w < 3; w++) begin
      for (int b = 0; b < BN; b++) send_beat(DW'(8'h10 * w + b + 1), 1'b0);
    end
    idle(3);
    rec_on = 1'b0;
    check_val("t3_stalls", 64'(stall_cnt), 64'd0);
    check_val("t3_words", 64'(hsk_cyc.size()), 64'd3);
    if (hsk_cyc.size() == 3) begin
      check_val("t3_gap1", 64'(hsk_cyc[1] - hsk_cyc[0]), 64'd4);
      check_val("t3_gap2", 64'(hsk_cyc[2] - hsk_cyc[1]), 64'd4);
    end

    // Output stalled: second word pends and back-pressures the input
    fwd_rdy = 1'b0;
    for (int b = 0; b < BN; b++) send_beat(DW'(8'hA0 + b), 1'b0);
    for (int b = 0; b < BN; b++) send_beat(DW'(8'hB0 + b), 1'b0);
    bwd_vld = 1'b0;
    check_val("t4_rdy_low", {63'd0, bwd_rdy}, 64'd0);
    check_val("t4_hold_w1", {32'd0, fwd_data}, 64'hA3A2A1A0);
    idle(2);
    check_val("t4_still_w1", {32'd0, fwd_data}, 64'hA3A2A1A0);
    fwd_rdy = 1'b1;
    idle(1);
    check_val("t4_rdy_back", {63'd0, bwd_rdy}, 64'd1);
    check_val("t4_vld_w2", {63'd0, fwd_vld}, 64'd1);
    check_val("t4_data_w2", {32'd0, fwd_data}, 64'hB3B2B1B0);
    idle(2);

    // Reset in the middle of a word
    send_beat(8'hE1, 1'b0);
    send_beat(8'hE2, 1'b0);
    bwd_vld = 1'b0;
    rst_n = 1'b0;
    #1;
    check_val("t5_rst_vld", {63'd0, fwd_vld}, 64'd0);
    check_val("t5_rst_rdy", {63'd0, bwd_rdy}, 64'd1);
    model_clear();
    idle(2);
    rst_n = 1'b1;
    idle(1);
    send_beat(8'h01, 1'b0);
    send_beat(8'h02, 1'b0);
    send_beat(8'h03, 1'b0);
    send_beat(8'h04, 1'b0);
    bwd_vld = 1'b0;
    check_val("t5_data", {32'd0, fwd_data}, 64'h04030201);
    check_val("t5_keep", {60'd0, fwd_keep}, 64'hF);
    idle(2);

    // Single-beat word
    send_beat(8'h5C, 1'b1);
    bwd_vld = 1'b0;
    check_val("t6_data", {32'd0, fwd_data}, 64'h0000005C);
    check_val("t6_keep", {60'd0, fwd_keep}, 64'h1);
    idle(1);

    // Random traffic with random back-pressure
    for (int k = 0; k < 60; k++) begin
      fwd_rdy = ($urandom_range(0, 3) != 0);
      send_beat(DW'($urandom), ($urandom_range(0, 4) == 0));
    end
    bwd_vld = 1'b0;
    fwd_rdy = 1'b1;
    for (int t = 0; t < 50 && exp_q.size() != 0; t++) idle(1);
    idle(2);
    check_val("drain_empty", 64'(exp_q.size()), 64'd0);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
